// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer sequencer: owns a loadable up-counter and the
// FSM that arms, runs, pauses, reloads and stops it. Produces a registered
// one-cycle expire pulse, a sticky irq with overrun detection and a
// start_err pulse when arming is attempted with a zero period.
module interval_timer_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en_i,
  input  logic             cfg_wr_i,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_periodic_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  input  logic             irq_ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic [1:0]       state_o,
  output logic             expire_o,
  output logic             irq_o,
  output logic             overrun_o,
  output logic             start_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic             shadow_periodic_q, shadow_periodic_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             start_err_q, start_err_d;
  logic             run_step;
  logic             term_hit;

  // Next-state logic: shadow/irq bookkeeping every edge, FSM and counter only on enabled edges
  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    period_d          = period_q;
    periodic_d        = periodic_q;
    shadow_period_d   = cfg_wr_i ? cfg_period_i   : shadow_period_q;
    shadow_periodic_d = cfg_wr_i ? cfg_periodic_i : shadow_periodic_q;
    expire_d          = 1'b0;
    start_err_d       = 1'b0;
    run_step          = 1'b0;
    term_hit          = 1'b0;

    if (clk_en_i) begin
      if (stop_i) begin
        // stop dominates everything, including a terminal-count edge
        state_d = S_IDLE;
        count_d = '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              if (shadow_period_q == '0) begin
                start_err_d = 1'b1;
              end else begin
                count_d    = '0;
                period_d   = shadow_period_q;
                periodic_d = shadow_periodic_q;
                state_d    = S_RUN;
              end
            end
          end
          S_RUN: begin
            // start is meaningless in RUN, so pause is the only command left
            if (pause_i) state_d = S_PAUSE;
            else         run_step = 1'b1;
          end
          S_PAUSE: begin
            // resume edge counts like any RUN edge, so the frozen span equals the paused edges
            if (start_i) begin
              state_d  = S_RUN;
              run_step = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase

        if (run_step) begin
          if (count_q == period_q - ONE) begin
            term_hit = 1'b1;
            expire_d = 1'b1;
            if (periodic_q) begin
              count_d = '0;
              // a zero shadow period would make the counter wrap, so keep the old one
              if (shadow_period_q != '0) begin
                period_d   = shadow_period_q;
                periodic_d = shadow_periodic_q;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
    end

    // set beats acknowledge; overrun only when an unacknowledged irq is hit again
    irq_d     = term_hit | (irq_q & ~irq_ack_i);
    overrun_d = (term_hit & irq_q & ~irq_ack_i) | (overrun_q & ~irq_ack_i);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      count_q           <= '0;
      shadow_period_q   <= '0;
      shadow_periodic_q <= 1'b0;
      period_q          <= '0;
      periodic_q        <= 1'b0;
      expire_q          <= 1'b0;
      irq_q             <= 1'b0;
      overrun_q         <= 1'b0;
      start_err_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      shadow_period_q   <= shadow_period_d;
      shadow_periodic_q <= shadow_periodic_d;
      period_q          <= period_d;
      periodic_q        <= periodic_d;
      expire_q          <= expire_d;
      irq_q             <= irq_d;
      overrun_q         <= overrun_d;
      start_err_q       <= start_err_d;
    end
  end

  assign count_o     = count_q;
  assign state_o     = state_q;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign expire_o    = expire_q;
  assign irq_o       = irq_q;
  assign overrun_o   = overrun_q;
  assign start_err_o = start_err_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scenario bench for interval_timer_ctrl. Expected expire times (in enabled
// edges) are queued when a timer is armed and popped as expire pulses appear.
module tb_interval_timer_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clk_en = 1'b1;
  logic         cfg_wr = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic         cfg_periodic = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic [1:0]   state;
  logic         expire;
  logic         irq;
  logic         overrun;
  logic         start_err;

  int vectors = 0;
  int miscompares = 0;
  int en_cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en_i(clk_en), .cfg_wr_i(cfg_wr),
    .cfg_period_i(cfg_period), .cfg_periodic_i(cfg_periodic), .start_i(start),
    .pause_i(pause), .stop_i(stop), .irq_ack_i(irq_ack), .count_o(count),
    .busy_o(busy), .state_o(state), .expire_o(expire), .irq_o(irq),
    .overrun_o(overrun), .start_err_o(start_err)
  );

  // One clock edge; counts enabled edges, then settles 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    if (clk_en) en_cyc++;
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] p, input logic per);
    cfg_wr = 1'b1; cfg_period = p; cfg_periodic = per;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic idle_all();
    clk_en = 1'b1; stop = 1'b1; irq_ack = 1'b1;
    tick();
    stop = 1'b0; irq_ack = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++;
    if (state !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b want 00", state); end
    vectors++;
    if ({busy, expire, irq, overrun, start_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {busy, expire, irq, overrun, start_err});
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    vectors++;
    if (state !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release: state %b busy %b want 00/0", state, busy); end
    $display("reset checked");
  endtask

  task automatic test_oneshot();
    int s; int e;
    cfg(5, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    s = en_cyc; exp_q.push_back(s + 5);
    vectors++;
    if (state !== 2'b01 || count !== 0) begin miscompares++; $display("FAIL oneshot_arm: state %b count %0d want 01/0", state, count); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (expire) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL oneshot_expire: got edge %0d want none", en_cyc - s); end
        else begin
          e = exp_q.pop_front();
          $display("oneshot expire at edge %0d", en_cyc - s);
          if (en_cyc !== e) begin miscompares++; $display("FAIL oneshot_expire: got edge %0d want %0d", en_cyc - s, e - s); end
        end
        vectors++;
        if (count !== 4 || state !== 2'b11 || irq !== 1'b1) begin
          miscompares++; $display("FAIL oneshot_term: count %0d state %b irq %b want 4/11/1", count, state, irq);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL oneshot_missing: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    vectors++;
    if (count !== 4 || state !== 2'b11 || busy !== 1'b0) begin
      miscompares++; $display("FAIL oneshot_hold: count %0d state %b busy %b want 4/11/0", count, state, busy);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_ack: irq %b want 0", irq); end
  endtask

  task automatic test_periodic_reload();
    int s; int e;
    cfg(3, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    s = en_cyc;
    exp_q.push_back(s + 3); exp_q.push_back(s + 6);
    exp_q.push_back(s + 12); exp_q.push_back(s + 18);
    for (int i = 1; i <= 19; i++) begin
      cfg_wr = (i == 4);
      if (i == 4) cfg_period = 6;
      tick();
      if (expire) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL reload_expire: got edge %0d want none", en_cyc - s); end
        else begin
          e = exp_q.pop_front();
          $display("periodic expire at edge %0d", en_cyc - s);
          if (en_cyc !== e) begin miscompares++; $display("FAIL reload_expire: got edge %0d want %0d", en_cyc - s, e - s); end
        end
      end
    end
    cfg_wr = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL reload_missing: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    vectors++;
    if (count !== 1 || state !== 2'b01) begin miscompares++; $display("FAIL reload_count: count %0d state %b want 1/01", count, state); end
    idle_all();
  endtask

  task automatic test_clk_en_pause();
    int s; int e;
    cfg(4, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    s = en_cyc;
    exp_q.push_back(s + 4); exp_q.push_back(s + 8);
    exp_q.push_back(s + 22); exp_q.push_back(s + 26);
    for (int i = 0; i < 37; i++) begin
      // 20 cycles at 50% enable, then full enable with a 10-edge pause
      clk_en = (i < 20) ? ((i % 2) == 1) : 1'b1;
      pause  = (i == 20);
      start  = (i == 30);
      tick();
      if (expire) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL pause_expire: got edge %0d want none", en_cyc - s); end
        else begin
          e = exp_q.pop_front();
          $display("gated expire at edge %0d", en_cyc - s);
          if (en_cyc !== e) begin miscompares++; $display("FAIL pause_expire: got edge %0d want %0d", en_cyc - s, e - s); end
        end
      end
      if (i == 19) begin
        vectors++;
        if (count !== 2) begin miscompares++; $display("FAIL gated_count: got %0d want 2", count); end
      end
      if (i == 25) begin
        vectors++;
        if (count !== 2 || state !== 2'b10 || busy !== 1'b1) begin
          miscompares++; $display("FAIL pause_hold: count %0d state %b busy %b want 2/10/1", count, state, busy);
        end
      end
      if (i == 30) begin
        vectors++;
        if (count !== 3 || state !== 2'b01) begin miscompares++; $display("FAIL resume: count %0d state %b want 3/01", count, state); end
      end
    end
    pause = 1'b0; start = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL pause_missing: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    idle_all();
  endtask

  task automatic test_stop();
    cfg(3, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    vectors++;
    if (expire !== 1'b0 || count !== 0 || state !== 2'b00 || irq !== 1'b0) begin
      miscompares++; $display("FAIL stop_terminal: expire %b count %0d state %b irq %b want 0/0/00/0", expire, count, state, irq);
    end
    tick();
    vectors++;
    if (expire !== 1'b0) begin miscompares++; $display("FAIL stop_late_expire: got %b want 0", expire); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    vectors++;
    if (state !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL start_stop: state %b busy %b want 00/0", state, busy); end
    pause = 1'b1; tick(); pause = 1'b0;
    vectors++;
    if (state !== 2'b00) begin miscompares++; $display("FAIL idle_pause: state %b want 00", state); end
    $display("stop sequence checked");
  endtask

  task automatic test_p1_overrun();
    cfg(1, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (irq !== 1'b0 || expire !== 1'b0) begin miscompares++; $display("FAIL p1_arm: irq %b expire %b want 0/0", irq, expire); end
    tick();
    vectors++;
    if (expire !== 1'b1 || irq !== 1'b1 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL p1_first: expire %b irq %b overrun %b want 1/1/0", expire, irq, overrun);
    end
    tick();
    vectors++;
    if (expire !== 1'b1 || overrun !== 1'b1) begin miscompares++; $display("FAIL p1_overrun: expire %b overrun %b want 1/1", expire, overrun); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    vectors++;
    if (irq !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL p1_ack_race: irq %b overrun %b want 1/0", irq, overrun); end
    $display("p1 overrun sequence checked");
    idle_all();
  endtask

  task automatic test_start_err();
    cfg(0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (start_err !== 1'b1 || state !== 2'b00) begin miscompares++; $display("FAIL start_err: start_err %b state %b want 1/00", start_err, state); end
    tick();
    vectors++;
    if (start_err !== 1'b0) begin miscompares++; $display("FAIL start_err_pulse: got %b want 0", start_err); end
    clk_en = 1'b0; start = 1'b1; tick(); start = 1'b0; clk_en = 1'b1;
    vectors++;
    if (start_err !== 1'b0) begin miscompares++; $display("FAIL start_err_gated: got %b want 0", start_err); end
  endtask

  task automatic test_reset_midrun();
    cfg(2, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (irq !== 1'b1 || count !== 1 || state !== 2'b01) begin
      miscompares++; $display("FAIL midrun_pre: irq %b count %0d state %b want 1/1/01", irq, count, state);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 0 || state !== 2'b00 || {busy, expire, irq, overrun, start_err} !== 5'b0) begin
      miscompares++; $display("FAIL midrun_reset: count %0d state %b flags %b want 0/00/00000", count, state, {busy, expire, irq, overrun, start_err});
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (start_err !== 1'b1 || state !== 2'b00) begin
      miscompares++; $display("FAIL reset_shadow: start_err %b state %b want 1/00", start_err, state);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_reload();
    test_clk_en_pause();
    test_stop();
    test_p1_overrun();
    test_start_err();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
